// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, BCD sizing helper and add-3 threshold for div_result_bcd.
package div_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    localparam logic [3:0] ADD3_MIN = 4'd5;

    // Number of decimal digits needed to represent 2^width-1.
    function automatic int bcd_digits(input int width);
        longint max_val = (longint'(1) << width) - 1;
        longint p = 10;
        int d = 1;
        while (p <= max_val) begin
            p = p * 10;
            d = d + 1;
        end
        return d;
    endfunction
endpackage

// File: rtl/bcd_shift_core.sv
// bcd_shift_core: one value's binary shift register and BCD accumulator, one double-dabble step per enable.
import div_pkg::*;

module bcd_shift_core #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   bin_in,
    output logic [4*D-1:0] bcd
);
    logic [W-1:0]   bin;
    logic [4*D-1:0] adj;

    for (genvar i = 0; i < D; i++) begin : g_adj
        assign adj[4*i+:4] = (bcd[4*i+:4] >= ADD3_MIN) ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd <= '0;
            bin <= '0;
        end else if (load) begin
            bcd <= '0;
            bin <= bin_in;
        end else if (step) begin
            {bcd, bin} <= {adj, bin} << 1;
        end
    end
endmodule

// File: rtl/div_result_bcd.sv
// div_result_bcd: captures divider quotient/remainder on Ready rise, converts both to BCD serially,
// and presents them over a valid/ready handshake.
import div_pkg::*;

module div_result_bcd #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int DIGITS          = 3
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       InValid,
    input  logic [INPUT_BIT_WIDTH-1:0] Quotient,
    input  logic [INPUT_BIT_WIDTH-1:0] Remainder,
    output logic                       Busy,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [4*DIGITS-1:0]        QuotientBcd,
    output logic [4*DIGITS-1:0]        RemainderBcd,
    output logic                       Overrun
);
    localparam int CW = $clog2(INPUT_BIT_WIDTH + 1);

    if (DIGITS < bcd_digits(INPUT_BIT_WIDTH)) begin : g_digits_check
        $fatal(1, "DIGITS too small for INPUT_BIT_WIDTH");
    end

    state_t              state, state_n;
    logic                hist, rise, capture, step, load_out;
    logic [CW-1:0]       cnt, cnt_n;
    logic [4*DIGITS-1:0] q_bcd, r_bcd;

    assign rise     = InValid & ~hist;
    assign capture  = rise & ((state == IDLE) | ((state == HOLD) & OutReady));
    assign step     = (state == SHIFT) & (cnt != '0);
    // Outputs load one cycle after the last shift, once the accumulators hold the final digits.
    assign load_out = (state == SHIFT) & (cnt == '0);
    assign Busy     = state != IDLE;
    assign OutValid = state == HOLD;

    always_comb begin
        state_n = state;
        cnt_n   = capture ? CW'(INPUT_BIT_WIDTH) : step ? cnt - 1'b1 : cnt;
        case (state)
            IDLE:    state_n = capture ? SHIFT : IDLE;
            SHIFT:   state_n = load_out ? HOLD : SHIFT;
            HOLD:    state_n = OutReady ? (capture ? SHIFT : IDLE) : HOLD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            hist         <= 1'b0;
            cnt          <= '0;
            QuotientBcd  <= '0;
            RemainderBcd <= '0;
            Overrun      <= 1'b0;
        end else begin
            state <= state_n;
            hist  <= InValid;
            cnt   <= cnt_n;
            if (load_out) begin
                QuotientBcd  <= q_bcd;
                RemainderBcd <= r_bcd;
            end
            if (rise & ~capture) Overrun <= 1'b1;
        end
    end

    bcd_shift_core #(.W(INPUT_BIT_WIDTH), .D(DIGITS)) u_q (
        .clk(Clk), .rst(Reset), .load(capture), .step(step), .bin_in(Quotient), .bcd(q_bcd)
    );

    bcd_shift_core #(.W(INPUT_BIT_WIDTH), .D(DIGITS)) u_r (
        .clk(Clk), .rst(Reset), .load(capture), .step(step), .bin_in(Remainder), .bcd(r_bcd)
    );
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: directed self-checking bench for div_result_bcd.
module tb_div_result_bcd;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic [7:0]  Quotient = '0;
    logic [7:0]  Remainder = '0;
    logic        OutReady = 1'b0;
    logic        Busy, OutValid, Overrun;
    logic [11:0] QuotientBcd, RemainderBcd;

    int checks = 0;
    int errors = 0;

    div_result_bcd dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .Quotient(Quotient), .Remainder(Remainder),
        .Busy(Busy), .OutValid(OutValid), .OutReady(OutReady),
        .QuotientBcd(QuotientBcd), .RemainderBcd(RemainderBcd), .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!OutValid && n < 30) begin
            tick();
            n++;
        end
        check(tag, OutValid, 1);
    endtask

    task automatic ack();
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
    endtask

    task automatic convert(input logic [7:0] q, input logic [7:0] r, input logic [11:0] eq, input logic [11:0] er);
        Quotient = q;
        Remainder = r;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        wait_valid("conv_timeout");
        check("conv_q", QuotientBcd, eq);
        check("conv_r", RemainderBcd, er);
        ack();
        check("conv_ack_valid", OutValid, 0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        check("rst_valid", OutValid, 0);
        check("rst_busy", Busy, 0);
        check("rst_q", QuotientBcd, 0);
        check("rst_r", RemainderBcd, 0);
        check("rst_ovr", Overrun, 0);
        Reset = 1'b0;
        tick();

        // 13/2: latency and Busy window
        Quotient = 8'd6;
        Remainder = 8'd1;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check("lat_busy_k", Busy, 1);
        repeat (8) tick();
        check("lat_busy_k8", Busy, 1);
        check("lat_early", OutValid, 0);
        tick();
        check("lat_valid_k9", OutValid, 1);
        check("lat_q", QuotientBcd, 12'h006);
        check("lat_r", RemainderBcd, 12'h001);

        // stall in HOLD
        Quotient = 8'd77;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_valid", OutValid, 1);
            check("hold_q", QuotientBcd, 12'h006);
            check("hold_r", RemainderBcd, 12'h001);
        end
        ack();
        check("ack_valid", OutValid, 0);
        check("ack_busy", Busy, 0);

        convert(8'd255, 8'd254, 12'h255, 12'h254);
        convert(8'd0, 8'd0, 12'h000, 12'h000);
        convert(8'd99, 8'd37, 12'h099, 12'h037);
        convert(8'd100, 8'd9, 12'h100, 12'h009);

        // rise during SHIFT is dropped
        Quotient = 8'd6;
        Remainder = 8'd1;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        repeat (3) tick();
        Quotient = 8'd99;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check("ovr_set", Overrun, 1);
        wait_valid("ovr_timeout");
        check("ovr_q", QuotientBcd, 12'h006);
        check("ovr_r", RemainderBcd, 12'h001);
        check("ovr_sticky", Overrun, 1);
        ack();
        check("ovr_sticky2", Overrun, 1);

        // reset clears Overrun; then back-to-back capture on completing HOLD edge
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("ovr_clr", Overrun, 0);
        Quotient = 8'd200;
        Remainder = 8'd13;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        wait_valid("b2b_timeout");
        check("b2b_q1", QuotientBcd, 12'h200);
        Quotient = 8'd42;
        Remainder = 8'd7;
        InValid = 1'b1;
        OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        OutReady = 1'b0;
        check("b2b_valid", OutValid, 0);
        check("b2b_busy", Busy, 1);
        check("b2b_ovr", Overrun, 0);
        wait_valid("b2b2_timeout");
        check("b2b_q2", QuotientBcd, 12'h042);
        check("b2b_r2", RemainderBcd, 12'h007);
        check("b2b_ovr2", Overrun, 0);
        ack();

        // reset mid-SHIFT with InValid held high through release
        Quotient = 8'd6;
        Remainder = 8'd1;
        InValid = 1'b1;
        tick();
        repeat (4) tick();
        check("mid_busy", Busy, 1);
        Reset = 1'b1;
        tick();
        check("mrst_busy", Busy, 0);
        check("mrst_valid", OutValid, 0);
        check("mrst_q", QuotientBcd, 0);
        check("mrst_r", RemainderBcd, 0);
        check("mrst_ovr", Overrun, 0);
        Quotient = 8'd123;
        Remainder = 8'd45;
        Reset = 1'b0;
        tick();
        check("post_rst_busy", Busy, 1);

        // InValid stays high: one conversion only
        OutReady = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (OutValid) begin
                n++;
                check("held_q", QuotientBcd, 12'h123);
                check("held_r", RemainderBcd, 12'h045);
            end
            tick();
        end
        OutReady = 1'b0;
        InValid = 1'b0;
        check("held_count", n, 1);
        check("held_ovr", Overrun, 0);
        check("held_busy", Busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
Downstream stage of the unsigned divider. It captures Quotient and Remainder when the divider's Ready rises. It converts both values to packed BCD with a serial shift-add-3 (double-dabble) engine, one bit per clock. It presents the digits to a display or UART formatter over a valid/ready handshake.

Parameters:
INPUT_BIT_WIDTH, 8, width of Quotient/Remainder; must match the divider instance.
DIGITS, 3, BCD digits per value; the integrator must guarantee 10^DIGITS > 2^INPUT_BIT_WIDTH-1 (elaboration-time check, fatal if violated).

Ports:
Clk  input  1  rising-edge clock, shared with divider
Reset  input  1  synchronous, active-high reset
InValid  input  1  level; connect to divider Ready
Quotient  input  INPUT_BIT_WIDTH  divider quotient
Remainder  input  INPUT_BIT_WIDTH  divider remainder
Busy  output  1  high in SHIFT or HOLD
OutValid  output  1  BCD results valid
OutReady  input  1  consumer accepts results
QuotientBcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0]
RemainderBcd  output  4*DIGITS  packed BCD
Overrun  output  1  sticky: a capture request was dropped

Behaviour:
- Reset (sampled high at a Clk edge):
  - State goes to IDLE.
  - QuotientBcd, RemainderBcd, OutValid, Busy and Overrun go to 0.
  - The InValid history register goes to 0.
  - Reset overrides all other activity, including mid-SHIFT or HOLD.
- Capture trigger: a rise, i.e. InValid=1 at the current edge and the history register = 0.
  - The history register updates every cycle.
  - InValid already high when reset is released counts as a rise on the first edge after reset.
- States: IDLE, SHIFT, HOLD. Encoding is registered; Busy = (state != IDLE).
- IDLE:
  - On a rise: latch Quotient and Remainder into shift registers, clear the BCD accumulators, load bit counter = INPUT_BIT_WIDTH, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle, for both values in parallel:
  - Every BCD digit >= 5 gets +3.
  - Then shift {bcd, bin} left by 1, with the binary MSB entering BCD bit 0.
  - The counter decrements. When it reaches 0 after the INPUT_BIT_WIDTH-th shift, load the outputs and go to HOLD with OutValid=1.
  - QuotientBcd and RemainderBcd change only on this load.
- Latency: the rise is sampled at edge k; OutValid is visible after edge k+INPUT_BIT_WIDTH+1 (9 edges for the default width).
- HOLD:
  - OutValid=1; outputs stay stable while OutReady=0.
  - On an edge with OutReady=1: transfer completes and OutValid drops at that edge.
  - If a rise is sampled on that same edge, capture it and go directly to SHIFT. Otherwise go to IDLE.
- Rise sampled in SHIFT, or in HOLD without a completing transfer:
  - Ignore it and set Overrun=1; it is cleared only by Reset.
  - The in-flight conversion is unaffected.
- Output values: BCD digits are always 0-9. Unused high digits are 0 (no blanking).
- Inputs are sampled only at the capture edge. Changes to Quotient or Remainder afterwards have no effect.

Decomposition:
- Shared package div_pkg holds:
  - the state encoding constants (IDLE/SHIFT/HOLD);
  - a constant function bcd_digits(width) for the DIGITS check;
  - the add-3 threshold constant.
- One natural sub-module: bcd_shift_core, which holds one value's binary shift register, its BCD accumulator and the per-cycle add-3/shift step.
  - It has load and step enables.
  - It is instantiated twice (quotient, remainder).
  - The top holds the FSM, counter, edge detect, Overrun and output registers.

Test Plan:
1. Divider 13/2 (Q=6, R=1), InValid rises at edge k -> OutValid high after edge k+9, QuotientBcd=12'h006, RemainderBcd=12'h001, Busy high edges k+1..k+9.
2. Q=255, R=254 -> QuotientBcd=12'h255, RemainderBcd=12'h254; Q=0, R=0 -> 12'h000, 12'h000.
3. OutReady held 0 for 20 cycles in HOLD -> OutValid and both BCD outputs constant; one-cycle OutReady pulse -> OutValid low after that edge, state IDLE, Busy 0.
4. Second InValid rise 3 cycles into SHIFT (new Q=99) -> ignored, Overrun=1 sticky, delivered result is the first pair; HOLD edge with OutReady=1 coincident with a rise -> immediate new SHIFT, no Overrun.
5. Reset asserted mid-SHIFT (cycle 4) -> after that edge all outputs 0, state IDLE, Overrun 0; InValid held high through reset release -> one conversion starts on the first post-reset edge.
6. InValid held high continuously for 50 cycles -> exactly one conversion and one OutValid transfer, Overrun stays 0.
